alu_secuencial: RTL and testbench

Parametrised, clocked successor of the combinational M-bit ALU. It adds a start/busy/done handshake, registered result and flags, and iterative multi-cycle multiply/divide/modulo, so M can scale without deep combinational paths. It sits between the operand/opcode source (switch/button front end or controller) and the display/flag logic. It accepts one operation per start pulse.

---
 rtl/alu_secuencial_pkg.sv | 29 ++
 rtl/alu_secuencial_muldiv.sv | 90 +++++++++
 rtl/alu_secuencial.sv | 207 ++++++++++++++++++++
 tb/tb_alu_secuencial.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_secuencial_pkg.sv
// Shared types for the sequential ALU: opcodes, controller states and the flag bundle.
package alu_secuencial_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0100,
    OP_DIV = 4'b0101,
    OP_MOD = 4'b0110,
    OP_AND = 4'b1000,
    OP_OR  = 4'b1001,
    OP_XOR = 4'b1010,
    OP_SHL = 4'b1100,
    OP_SHR = 4'b1101
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic c;
    logic n;
    logic v;
    logic z;
  } flags_t;

endpackage

// File: rtl/alu_secuencial_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per clock.
// Outputs show the value after the current step so the caller can capture them on the final edge.
module alu_secuencial_muldiv
  import alu_secuencial_pkg::*;
#(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  op_e          op,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         last,
  output logic [M-1:0] P_hi,
  output logic [M-1:0] P_lo,
  output logic [M-1:0] Q,
  output logic [M-1:0] Rem
);

  localparam int CW = $clog2(M);

  logic [M-1:0]  hi_q, hi_d;
  logic [M-1:0]  lo_q, lo_d;
  logic [M-1:0]  opnd_q, opnd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mul_q, mul_d;
  logic          act_q, act_d;
  logic [M:0]    sum;
  logic [M:0]    shifted;
  logic          ge;

  assign last = act_q && (cnt_q == CW'(M - 1));

  // hi holds the partial product / remainder, lo the multiplier / dividend-becoming-quotient
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    act_d   = act_q;
    sum     = {1'b0, hi_q} + {1'b0, opnd_q};
    shifted = {hi_q, lo_q[M-1]};
    ge      = (shifted >= {1'b0, opnd_q});
    if (load) begin
      hi_d   = '0;
      lo_d   = A;
      opnd_d = B;
      cnt_d  = '0;
      mul_d  = (op == OP_MUL);
      act_d  = 1'b1;
    end else if (act_q) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
      act_d = !last;
      if (mul_q) begin
        if (lo_q[0]) {hi_d, lo_d} = {sum, lo_q[M-1:1]};
        else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[M-1:1]};
      end else begin
        // difference is below the divisor, so it always fits in M bits
        hi_d = ge ? (shifted[M-1:0] - opnd_q) : shifted[M-1:0];
        lo_d = {lo_q[M-2:0], ge};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      mul_q  <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      mul_q  <= mul_d;
      act_q  <= act_d;
    end
  end

  assign P_hi = hi_d;
  assign P_lo = lo_d;
  assign Q    = lo_d;
  assign Rem  = hi_d;

endmodule

// File: rtl/alu_secuencial.sv
// Clocked M-bit ALU with start/busy/done handshake and registered result/flags.
// ALU_SECUENCIAL_MULDIV_EN enables iterative mul/div/mod; otherwise those opcodes are unsupported.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// RUN   | iterative mul/div/mod in progress, one step per clock
module alu_secuencial
  import alu_secuencial_pkg::*;
#(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic [3:0]   F,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] R,
  output logic         C,
  output logic         N,
  output logic         V,
  output logic         Z
);

  logic [M-1:0] r_q, r_d;
  flags_t       flg_q, flg_d;
  logic         done_q, done_d;

  logic [M-1:0] sc_r;
  flags_t       sc_f;
  logic         sc_nz;
  logic [M:0]   sum;
  logic [M:0]   shl_w;
  logic [M:0]   shr_w;
  logic [M-1:0] diff;

  // single-cycle result; the extra bit on each shift catches the last bit shifted out
  always_comb begin
    sc_r  = '1;
    sc_f  = '0;
    sc_nz = 1'b1;
    sum   = {1'b0, A} + {1'b0, B};
    diff  = A - B;
    shl_w = {1'b0, A} << B;
    shr_w = {A, 1'b0} >> B;
    case (F)
      OP_ADD: begin
        sc_r   = sum[M-1:0];
        sc_f.c = sum[M];
        sc_f.v = (A[M-1] == B[M-1]) && (sum[M-1] != A[M-1]);
      end
      OP_SUB: begin
        sc_r   = diff;
        sc_f.c = (A >= B);
        sc_f.v = (A[M-1] != B[M-1]) && (diff[M-1] != A[M-1]);
      end
      OP_AND: sc_r = A & B;
      OP_OR:  sc_r = A | B;
      OP_XOR: sc_r = A ^ B;
      OP_SHL: begin
        sc_r   = shl_w[M-1:0];
        sc_f.c = shl_w[M];
      end
      OP_SHR: begin
        sc_r   = shr_w[M:1];
        sc_f.c = shr_w[0];
      end
`ifdef ALU_SECUENCIAL_MULDIV_EN
      OP_DIV, OP_MOD: begin
        sc_r   = '1;
        sc_f.v = 1'b1;
      end
`endif
      default: begin
        sc_r  = '1;
        sc_nz = 1'b0;
      end
    endcase
    if (sc_nz) begin
      sc_f.n = sc_r[M-1];
      sc_f.z = (sc_r == '0);
    end
  end

`ifdef ALU_SECUENCIAL_MULDIV_EN
  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic         start_multi;
  logic         md_load;
  logic         md_last;
  logic [M-1:0] p_hi, p_lo, quo, rem;
  logic [M-1:0] md_r;
  flags_t       md_f;

  assign start_multi = (F == OP_MUL) || (((F == OP_DIV) || (F == OP_MOD)) && (B != '0));

  alu_secuencial_muldiv #(.M(M)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (md_load),
    .op    (op_e'(F)),
    .A     (A),
    .B     (B),
    .last  (md_last),
    .P_hi  (p_hi),
    .P_lo  (p_lo),
    .Q     (quo),
    .Rem   (rem)
  );

  always_comb begin
    md_r = rem;
    md_f = '0;
    case (op_q)
      OP_MUL: begin
        md_r   = p_lo;
        md_f.c = (p_hi != '0);
        md_f.v = (p_hi != '0);
      end
      OP_DIV:  md_r = quo;
      default: md_r = rem;
    endcase
    md_f.n = md_r[M-1];
    md_f.z = (md_r == '0);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r_d     = r_q;
    flg_d   = flg_q;
    done_d  = 1'b0;
    md_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_multi) begin
            md_load = 1'b1;
            op_d    = op_e'(F);
            state_d = RUN;
          end else begin
            r_d    = sc_r;
            flg_d  = sc_f;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (md_last) begin
          r_d     = md_r;
          flg_d   = md_f;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign busy = (state_q == RUN);
`else
  always_comb begin
    r_d    = r_q;
    flg_d  = flg_q;
    done_d = 1'b0;
    if (start) begin
      r_d    = sc_r;
      flg_d  = sc_f;
      done_d = 1'b1;
    end
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      flg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      flg_q  <= flg_d;
      done_q <= done_d;
    end
  end

  assign R    = r_q;
  assign C    = flg_q.c;
  assign N    = flg_q.n;
  assign V    = flg_q.v;
  assign Z    = flg_q.z;
  assign done = done_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed vector bench for alu_secuencial at M=4 and M=8, plus handshake corner sequences.
module tb_alu_secuencial;

  typedef struct {
    int         w;
    logic [3:0] f;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] flg;
    logic       chk_c;
    int         lat;
  } vec_t;

  localparam int NV = 26;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, f4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] f8 = '0;
  logic       busy4, done4, C4, N4, V4, Z4;
  logic       busy8, done8, C8, N8, V8, Z8;
  logic [3:0] R4;
  logic [7:0] R8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_secuencial #(.M(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .F(f4),
    .busy(busy4), .done(done4), .R(R4), .C(C4), .N(N4), .V(V4), .Z(Z4)
  );

  alu_secuencial #(.M(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .F(f8),
    .busy(busy8), .done(done8), .R(R8), .C(C8), .N(N8), .V(V8), .Z(Z8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input int w, input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic [3:0] flg, output int lat,
                        output int nbusy, output logic both);
    @(negedge clk);
    if (w == 4) begin f4 = f; a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1; end
    else        begin f8 = f; a8 = a;      b8 = b;      start8 = 1'b1; end
    lat = 0; nbusy = 0; both = 1'b0; r = '0; flg = '0;
    while (lat < 40) begin
      @(negedge clk);
      start4 = 1'b0; start8 = 1'b0;
      lat++;
      if (w == 4) begin
        if (busy4) nbusy++;
        if (busy4 && done4) both = 1'b1;
        if (done4) begin r = {4'h0, R4}; flg = {C4, N4, V4, Z4}; break; end
      end else begin
        if (busy8) nbusy++;
        if (busy8 && done8) both = 1'b1;
        if (done8) begin r = R8; flg = {C8, N8, V8, Z8}; break; end
      end
    end
  endtask

  initial begin
    vec_t       vt[NV];
    vec_t       e;
    logic [7:0] r;
    logic [3:0] flg;
    int         lat, nbusy, cyc, ndone;
    logic       both;

    //        w  f        a      b      r      CNVZ     chk lat
    vt[0]  = '{4, 4'b0000, 8'h7,  8'h9,  8'h0,  4'b1001, 1, 1};
    vt[1]  = '{4, 4'b0001, 8'h3,  8'h5,  8'hE,  4'b0100, 1, 1};
    vt[2]  = '{4, 4'b0001, 8'h8,  8'h1,  8'h7,  4'b1010, 1, 1};
    vt[3]  = '{4, 4'b0000, 8'h4,  8'h4,  8'h8,  4'b0110, 1, 1};
    vt[4]  = '{4, 4'b1000, 8'hC,  8'hA,  8'h8,  4'b0100, 1, 1};
    vt[5]  = '{4, 4'b1001, 8'h5,  8'h2,  8'h7,  4'b0000, 1, 1};
    vt[6]  = '{4, 4'b1010, 8'h9,  8'h9,  8'h0,  4'b0001, 1, 1};
    vt[7]  = '{4, 4'b0011, 8'h5,  8'h3,  8'hF,  4'b0000, 1, 1};
    vt[8]  = '{4, 4'b0100, 8'h5,  8'h6,  8'hE,  4'b1110, 1, 5};
    vt[9]  = '{4, 4'b0101, 8'hD,  8'h4,  8'h3,  4'b0000, 1, 5};
    vt[10] = '{4, 4'b0110, 8'hD,  8'h4,  8'h1,  4'b0000, 1, 5};
    vt[11] = '{4, 4'b0101, 8'h9,  8'h0,  8'hF,  4'b0110, 1, 1};
    vt[12] = '{4, 4'b0100, 8'h3,  8'h5,  8'hF,  4'b0100, 1, 5};
    vt[13] = '{4, 4'b0110, 8'h7,  8'h7,  8'h0,  4'b0001, 1, 5};
    vt[14] = '{4, 4'b0101, 8'hF,  8'h1,  8'hF,  4'b0100, 1, 5};
    vt[15] = '{4, 4'b0100, 8'h0,  8'h9,  8'h0,  4'b0001, 1, 5};
    vt[16] = '{8, 4'b1100, 8'h81, 8'h01, 8'h02, 4'b1000, 1, 1};
    vt[17] = '{8, 4'b1101, 8'h81, 8'h09, 8'h00, 4'b0001, 0, 1};
    vt[18] = '{8, 4'b0011, 8'h81, 8'h01, 8'hFF, 4'b0000, 1, 1};
    vt[19] = '{8, 4'b1101, 8'h81, 8'h01, 8'h40, 4'b1000, 1, 1};
    vt[20] = '{8, 4'b1100, 8'h81, 8'h00, 8'h81, 4'b0100, 1, 1};
    vt[21] = '{8, 4'b1100, 8'h81, 8'h08, 8'h00, 4'b1001, 1, 1};
    vt[22] = '{8, 4'b0100, 8'h10, 8'h10, 8'h00, 4'b1011, 1, 9};
    vt[23] = '{8, 4'b0101, 8'hC8, 8'h07, 8'h1C, 4'b0000, 1, 9};
    vt[24] = '{8, 4'b0110, 8'hC8, 8'h07, 8'h04, 4'b0000, 1, 9};
    vt[25] = '{4, 4'b0110, 8'h5,  8'h0,  8'hF,  4'b0110, 1, 1};

    repeat (2) @(negedge clk);
    chk("reset_dut4", {R4, C4, N4, V4, Z4, busy4, done4}, '0);
    chk("reset_dut8", {R8, C8, N8, V8, Z8, busy8, done8}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      e = vt[i];
`ifndef ALU_SECUENCIAL_MULDIV_EN
      if (e.f == 4'b0100 || e.f == 4'b0101 || e.f == 4'b0110) begin
        e.r = (e.w == 4) ? 8'h0F : 8'hFF; e.flg = 4'b0000; e.chk_c = 1'b1; e.lat = 1;
      end
`endif
      run_op(e.w, e.f, e.a, e.b, r, flg, lat, nbusy, both);
      if (e.chk_c) chk($sformatf("vec%0d_result", i), {r, flg}, {e.r, e.flg});
      else         chk($sformatf("vec%0d_result_nvz", i), {r, flg[2:0]}, {e.r, e.flg[2:0]});
      chk($sformatf("vec%0d_latency", i), lat, e.lat);
      chk($sformatf("vec%0d_busy_cycles", i), nbusy, e.lat - 1);
      chk($sformatf("vec%0d_busy_done_overlap", i), {31'd0, both}, 0);
    end

    // back-to-back single-cycle ops with start held high
    @(negedge clk);
    f4 = 4'b0000; a4 = 4'd1; b4 = 4'd2; start4 = 1'b1;
    @(negedge clk);
    chk("b2b_first", {done4, R4}, {1'b1, 4'd3});
    f4 = 4'b1010; a4 = 4'd6; b4 = 4'd3;
    @(negedge clk);
    chk("b2b_second", {done4, R4}, {1'b1, 4'd5});
    start4 = 1'b0;
    @(negedge clk);
    chk("b2b_done_drops", {31'd0, done4}, 0);

`ifdef ALU_SECUENCIAL_MULDIV_EN
    // start pulsed mid-busy must be ignored
    @(negedge clk);
    f4 = 4'b0100; a4 = 4'd5; b4 = 4'd6; start4 = 1'b1;
    cyc = 0; ndone = 0;
    while (cyc < 20 && !done4) begin
      @(negedge clk);
      cyc++;
      start4 = (cyc == 2);
      if (cyc == 2) begin f4 = 4'b0000; a4 = 4'd1; b4 = 4'd1; end
    end
    start4 = 1'b0;
    chk("midbusy_latency", cyc, 5);
    chk("midbusy_result", {R4, C4, N4, V4, Z4}, {4'hE, 4'b1110});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("midbusy_no_extra_done", ndone, 0);

    // new start accepted in the done cycle of a multi-cycle op
    @(negedge clk);
    f4 = 4'b0100; a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
    cyc = 0;
    while (cyc < 20 && !done4) begin
      @(negedge clk);
      start4 = 1'b0;
      cyc++;
    end
    chk("chain_mul_result", {R4, C4, N4, V4, Z4}, {4'd9, 4'b0100});
    f4 = 4'b0101; a4 = 4'd9; b4 = 4'd2; start4 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start4 = 1'b0;
      cyc++;
    end while (cyc < 20 && !done4);
    chk("chain_div_latency", cyc, 5);
    chk("chain_div_result", {R4, C4, N4, V4, Z4}, {4'd4, 4'b0000});
`endif

    // set a non-zero result, then reset during the third RUN cycle of a mul
    run_op(4, 4'b1001, 8'h6, 8'h1, r, flg, lat, nbusy, both);
    chk("pre_reset_result", {28'd0, r[3:0]}, 4'h7);
    @(negedge clk);
    f4 = 4'b0100; a4 = 4'd5; b4 = 4'd6; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
`ifdef ALU_SECUENCIAL_MULDIV_EN
    chk("busy_before_reset", {31'd0, busy4}, 1);
`else
    chk("no_busy_without_muldiv", {R4, busy4}, {4'hF, 1'b0});
`endif
    rst_n = 1'b0;
    #1;
    chk("reset_mid_run", {R4, C4, N4, V4, Z4, busy4, done4}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done4 || busy4) ndone++;
    end
    chk("reset_no_done", ndone, 0);
    run_op(4, 4'b0000, 8'h2, 8'h3, r, flg, lat, nbusy, both);
    chk("post_reset_add", {r, flg, 24'(lat)}, {8'h05, 4'b0000, 24'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
